axil_reg_responder: RTL and testbench
=====================================

Name: axil_reg_responder

Overview:
- AXI4-Lite responder (slave) that terminates the AXI master port of the WB2AXI bridge path, and is also usable as a standalone AXI-Lite peripheral.
- Holds a bank of NREGS 32-bit registers with byte-strobe writes and returns OKAY/SLVERR responses.
- The write and read channels run independently and concurrently, each with at most one transaction outstanding.

Parameters:
AW, 12, AXI byte-address width
NREGS, 16, number of 32-bit registers (2..2^(AW-2))

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_awaddr  in  AW  write address (byte)
i_awvalid  in  1  write address valid
o_awready  out  1  write address ready
i_wdata  in  32  write data
i_wstrb  in  4  write byte strobes
i_wvalid  in  1  write data valid
o_wready  out  1  write data ready
o_bresp  out  2  write response
o_bvalid  out  1  write response valid
i_bready  in  1  write response ready
i_araddr  in  AW  read address (byte)
i_arvalid  in  1  read address valid
o_arready  out  1  read address ready
o_rdata  out  32  read data
o_rresp  out  2  read response
o_rlast  out  1  tied 1
o_rvalid  out  1  read valid
i_rready  in  1  read ready

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: all registers = 0, aw_full = 0, w_full = 0, o_bvalid = 0, o_rvalid = 0, o_rdata = 0, o_bresp = 00, o_rresp = 00.
- Ready enable: internal flag en is cleared by reset and set on the first edge after i_rst deasserts. All readies are 0 while en = 0.
- Decode: idx = addr[AW-1:2]; addr[1:0] is ignored. idx < NREGS is OKAY (00), otherwise SLVERR (10).

Write FSM (W_COLLECT, W_RESP):
- In W_COLLECT: o_awready = en & !aw_full; o_wready = en & !w_full. Both are combinational from registered state only.
- On an AW handshake, latch the address and set aw_full. On a W handshake, latch data and strobes and set w_full. AW and W may arrive in either order or in the same cycle.
- When aw_full & w_full (registered), on the next edge:
  - commit the write: bytes selected by the strobes, only if in range;
  - o_bvalid <= 1, o_bresp <= decode result;
  - go to W_RESP.
- Latency: both accepted at edge k → commit and o_bvalid visible after edge k+1.
- W_RESP: o_awready = o_wready = 0. Hold o_bvalid and o_bresp stable until i_bready. On the edge with i_bvalid & i_bready, clear o_bvalid, aw_full and w_full and return to W_COLLECT. A new AW/W can be accepted the following cycle.
- An out-of-range write or wstrb = 0 changes no register but still responds.

Read FSM (R_IDLE, R_RESP):
- o_arready = en & !o_rvalid.
- On an AR handshake at edge k: o_rdata <= in range ? reg[idx] : 32'h0; o_rresp <= decode; o_rvalid <= 1.
- Hold o_rdata, o_rresp and o_rvalid until i_rready. The edge with o_rvalid & i_rready clears o_rvalid; o_rdata keeps its last value.
- Write commit and AR handshake on the same edge to the same register: the read returns the pre-write value.

Reset mid-operation: any in-flight or pending transaction is discarded and all state returns to reset values on the reset edge. The master must reissue.

Decomposition:
- Shared package axil_pkg: RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, write and read state encodings.
- Sub-module axil_regfile: NREGS x 32 registers, one write port with byte enables, one combinational read port, synchronous clear on reset.

Test Plan:
1. AW 0x008 and W 0xA5A5_1234 / strb F in the same cycle → both handshake; bvalid rises one cycle later with bresp 00. Read 0x008 → rdata 0xA5A5_1234, rresp 00, rlast 1.
2. W issued 3 cycles before AW; bready held low 5 cycles → wready low after W accept; bvalid one cycle after AW accept; bvalid stays high with awready/wready 0 until bready, then accepts a new write.
3. Register holds 0x1234_5678; write 0xFFFF_FFFF with strb 0101 → read returns 0x12FF_56FF.
4. Write to 0x040 (idx 16, NREGS = 16) → bresp 10 and all registers unchanged. Read 0x040 → rdata 0, rresp 10.
5. Write commit edge coincides with an AR handshake to the same register (old 0x1, new 0x2) → first read returns 0x1, second read returns 0x2.
6. i_rst asserted while bvalid and rvalid are pending → both 0 after the reset edge and registers 0. Readies stay 0 until one edge after reset release, then go to 1.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register responder: response codes and
// the write/read channel state encodings.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      W_COLLECT = 1'b0,
      W_RESP    = 1'b1
   } wr_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_RESP = 1'b1
   } rd_state_t;

endpackage

// File: rtl/axil_regfile.sv
// Bank of NREGS 32-bit registers: one byte-enabled write port, one
// combinational read port (reads 0 for an index with no register behind it).
module axil_regfile
   import axil_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int IDXW  = 10
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_we,
   input  logic [IDXW-1:0] i_widx,
   input  logic [31:0]     i_wdata,
   input  logic [3:0]      i_wstrb,
   input  logic [IDXW-1:0] i_ridx,
   output logic [31:0]     o_rdata
);

   logic [31:0] regs [NREGS];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (i_we) begin
         for (int i = 0; i < NREGS; i++) begin
            if (i_widx == IDXW'(i)) begin
               for (int b = 0; b < 4; b++) begin
                  if (i_wstrb[b]) regs[i][8*b +: 8] <= i_wdata[8*b +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      o_rdata = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (i_ridx == IDXW'(i)) o_rdata = regs[i];
      end
   end

endmodule

// File: rtl/axil_reg_responder.sv
// AXI4-Lite slave over a small register bank. Write and read channels are
// independent, each with a single transaction in flight.
module axil_reg_responder
   import axil_pkg::*;
#(
   parameter int AW    = 12,
   parameter int NREGS = 16
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [AW-1:0] i_awaddr,
   input  logic          i_awvalid,
   output logic          o_awready,
   input  logic [31:0]   i_wdata,
   input  logic [3:0]    i_wstrb,
   input  logic          i_wvalid,
   output logic          o_wready,
   output logic [1:0]    o_bresp,
   output logic          o_bvalid,
   input  logic          i_bready,
   input  logic [AW-1:0] i_araddr,
   input  logic          i_arvalid,
   output logic          o_arready,
   output logic [31:0]   o_rdata,
   output logic [1:0]    o_rresp,
   output logic          o_rlast,
   output logic          o_rvalid,
   input  logic          i_rready
);

   localparam int IDXW = AW - 2;

   function automatic logic idx_in_range(input logic [IDXW-1:0] idx);
      return 32'(idx) < NREGS;
   endfunction

   logic            en;
   wr_state_t       wr_state;
   rd_state_t       rd_state;
   logic            aw_full, w_full;
   logic [IDXW-1:0] aw_idx;
   logic [31:0]     w_data;
   logic [3:0]      w_strb;
   logic [IDXW-1:0] ar_idx;
   logic [31:0]     rf_rdata;
   logic            commit;
   logic            unused_addr_lsbs;

   assign unused_addr_lsbs = ^{i_awaddr[1:0], i_araddr[1:0]};
   assign ar_idx           = i_araddr[AW-1:2];

   // Readies depend only on registered state so they never loop back through the master.
   assign o_awready = en & (wr_state == W_COLLECT) & ~aw_full;
   assign o_wready  = en & (wr_state == W_COLLECT) & ~w_full;
   assign o_arready = en & ~o_rvalid;
   assign o_rlast   = 1'b1;
   assign commit    = (wr_state == W_COLLECT) & aw_full & w_full;

   axil_regfile #(.NREGS(NREGS), .IDXW(IDXW)) u_regfile (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (commit & idx_in_range(aw_idx)),
      .i_widx  (aw_idx),
      .i_wdata (w_data),
      .i_wstrb (w_strb),
      .i_ridx  (ar_idx),
      .o_rdata (rf_rdata)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) en <= 1'b0;
      else       en <= 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_awvalid & o_awready) aw_idx <= i_awaddr[AW-1:2];
      if (i_wvalid & o_wready) begin
         w_data <= i_wdata;
         w_strb <= i_wstrb;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_state <= W_COLLECT;
         aw_full  <= 1'b0;
         w_full   <= 1'b0;
         o_bvalid <= 1'b0;
         o_bresp  <= RESP_OKAY;
      end else begin
         case (wr_state)
            W_COLLECT: begin
               if (i_awvalid & o_awready) aw_full <= 1'b1;
               if (i_wvalid & o_wready)   w_full  <= 1'b1;
               if (commit) begin
                  o_bvalid <= 1'b1;
                  o_bresp  <= idx_in_range(aw_idx) ? RESP_OKAY : RESP_SLVERR;
                  wr_state <= W_RESP;
               end
            end
            W_RESP: begin
               if (i_bready) begin
                  o_bvalid <= 1'b0;
                  aw_full  <= 1'b0;
                  w_full   <= 1'b0;
                  wr_state <= W_COLLECT;
               end
            end
            default: wr_state <= W_COLLECT;
         endcase
      end
   end

   // Read data is sampled from the bank before any same-edge write lands.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_state <= R_IDLE;
         o_rvalid <= 1'b0;
         o_rdata  <= '0;
         o_rresp  <= RESP_OKAY;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (i_arvalid & o_arready) begin
                  o_rdata  <= rf_rdata;
                  o_rresp  <= idx_in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
                  o_rvalid <= 1'b1;
                  rd_state <= R_RESP;
               end
            end
            R_RESP: begin
               if (i_rready) begin
                  o_rvalid <= 1'b0;
                  rd_state <= R_IDLE;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_reg_responder.sv
// Bench for axil_reg_responder: directed vector table, multi-cycle corner
// sequences, and randomized traffic against an array-based register model.
module tb_axil_reg_responder;

   localparam int AW    = 12;
   localparam int NREGS = 16;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic [AW-1:0] i_awaddr;
   logic          i_awvalid;
   logic          o_awready;
   logic [31:0]   i_wdata;
   logic [3:0]    i_wstrb;
   logic          i_wvalid;
   logic          o_wready;
   logic [1:0]    o_bresp;
   logic          o_bvalid;
   logic          i_bready;
   logic [AW-1:0] i_araddr;
   logic          i_arvalid;
   logic          o_arready;
   logic [31:0]   o_rdata;
   logic [1:0]    o_rresp;
   logic          o_rlast;
   logic          o_rvalid;
   logic          i_rready;

   always #5 i_clk = ~i_clk;

   axil_reg_responder #(.AW(AW), .NREGS(NREGS)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
      .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
      .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
      .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(o_arready),
      .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
      .o_rvalid(o_rvalid), .i_rready(i_rready)
   );

   int errors = 0;
   int checks = 0;
   logic [31:0] model [NREGS];

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic [3:0]    strb;
      logic [1:0]    resp;
      logic [31:0]   rdata;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [1:0] model_write(input logic [AW-1:0] a, input logic [31:0] d,
                                              input logic [3:0] s);
      int idx = int'(a >> 2);
      if (idx >= NREGS) return 2'b10;
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      return 2'b00;
   endfunction

   function automatic logic [1:0] model_read(input logic [AW-1:0] a, output logic [31:0] d);
      int idx = int'(a >> 2);
      if (idx >= NREGS) begin
         d = 32'h0;
         return 2'b10;
      end
      d = model[idx];
      return 2'b00;
   endfunction

   task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int bdelay, output logic [1:0] resp);
      bit aw_pend = 1'b1;
      bit w_pend  = 1'b1;
      bit aw_hs, w_hs;
      int n = 0;
      i_awaddr = a; i_wdata = d; i_wstrb = s;
      i_awvalid = 1'b1; i_wvalid = 1'b1;
      while ((aw_pend || w_pend) && n < 20) begin
         aw_hs = i_awvalid & o_awready;
         w_hs  = i_wvalid & o_wready;
         tick; n++;
         if (aw_hs) begin i_awvalid = 1'b0; aw_pend = 1'b0; end
         if (w_hs)  begin i_wvalid  = 1'b0; w_pend  = 1'b0; end
      end
      i_awvalid = 1'b0; i_wvalid = 1'b0;
      if (aw_pend || w_pend) chk("wr_accept_timeout", 32'(aw_pend | w_pend), 0);
      repeat (bdelay) tick;
      i_bready = 1'b1;
      n = 0;
      while (!o_bvalid && n < 20) begin tick; n++; end
      if (!o_bvalid) chk("bvalid_timeout", 32'(o_bvalid), 1);
      resp = o_bresp;
      tick;
      i_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [AW-1:0] a, input int rdelay,
                           output logic [31:0] d, output logic [1:0] resp);
      int n = 0;
      i_araddr = a; i_arvalid = 1'b1;
      while (!o_arready && n < 20) begin tick; n++; end
      tick;
      i_arvalid = 1'b0;
      repeat (rdelay) tick;
      if (!o_rvalid) chk("rvalid_timeout", 32'(o_rvalid), 1);
      chk("rlast", 32'(o_rlast), 1);
      d = o_rdata;
      resp = o_rresp;
      i_rready = 1'b1;
      tick;
      i_rready = 1'b0;
   endtask

   initial begin
      logic [1:0]  resp, exp_resp;
      logic [31:0] rd, exp_d;
      logic [AW-1:0] a;
      logic [31:0] d;
      logic [3:0]  s;

      vecs[0]  = '{1'b1, 12'h008, 32'hA5A51234, 4'hF, 2'b00, 32'h0};
      vecs[1]  = '{1'b0, 12'h008, 32'h0,        4'h0, 2'b00, 32'hA5A51234};
      vecs[2]  = '{1'b1, 12'h00C, 32'h12345678, 4'hF, 2'b00, 32'h0};
      vecs[3]  = '{1'b1, 12'h00C, 32'hFFFFFFFF, 4'h5, 2'b00, 32'h0};
      vecs[4]  = '{1'b0, 12'h00C, 32'h0,        4'h0, 2'b00, 32'h12FF56FF};
      vecs[5]  = '{1'b1, 12'h040, 32'hDEADBEEF, 4'hF, 2'b10, 32'h0};
      vecs[6]  = '{1'b0, 12'h040, 32'h0,        4'h0, 2'b10, 32'h0};
      vecs[7]  = '{1'b0, 12'h008, 32'h0,        4'h0, 2'b00, 32'hA5A51234};
      vecs[8]  = '{1'b1, 12'h00B, 32'h0,        4'h0, 2'b00, 32'h0};
      vecs[9]  = '{1'b0, 12'h00A, 32'h0,        4'h0, 2'b00, 32'hA5A51234};
      vecs[10] = '{1'b1, 12'h3FC, 32'h1,        4'hF, 2'b10, 32'h0};
      vecs[11] = '{1'b0, 12'h03C, 32'h0,        4'h0, 2'b00, 32'h0};

      i_rst = 1'b1;
      i_awaddr = '0; i_awvalid = 1'b0; i_wdata = '0; i_wstrb = '0; i_wvalid = 1'b0;
      i_bready = 1'b0; i_araddr = '0; i_arvalid = 1'b0; i_rready = 1'b0;
      repeat (3) tick;

      chk("rst_bvalid",  32'(o_bvalid), 0);
      chk("rst_rvalid",  32'(o_rvalid), 0);
      chk("rst_rdata",   o_rdata, 0);
      chk("rst_bresp",   32'(o_bresp), 0);
      chk("rst_rresp",   32'(o_rresp), 0);
      chk("rst_awready", 32'(o_awready), 0);
      chk("rst_wready",  32'(o_wready), 0);
      chk("rst_arready", 32'(o_arready), 0);
      i_rst = 1'b0;
      chk("rel_awready_low", 32'(o_awready), 0);
      chk("rel_arready_low", 32'(o_arready), 0);
      tick;
      chk("en_awready", 32'(o_awready), 1);
      chk("en_wready",  32'(o_wready), 1);
      chk("en_arready", 32'(o_arready), 1);

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, resp);
            chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].resp));
         end else begin
            axi_read(vecs[i].addr, 0, rd, resp);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            chk($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].resp));
         end
      end

      // W leads AW by three cycles, then bready held off for five cycles
      i_wdata = 32'h0BADF00D; i_wstrb = 4'hF; i_wvalid = 1'b1;
      tick;
      i_wvalid = 1'b0;
      chk("w_first_wready", 32'(o_wready), 0);
      repeat (2) begin
         tick;
         chk("w_first_bvalid_idle", 32'(o_bvalid), 0);
      end
      i_awaddr = 12'h010; i_awvalid = 1'b1;
      tick;
      i_awvalid = 1'b0;
      chk("w_first_bvalid_aw_edge", 32'(o_bvalid), 0);
      tick;
      chk("w_first_bvalid", 32'(o_bvalid), 1);
      chk("w_first_bresp", 32'(o_bresp), 0);
      repeat (5) begin
         tick;
         chk("hold_bvalid",  32'(o_bvalid), 1);
         chk("hold_awready", 32'(o_awready), 0);
         chk("hold_wready",  32'(o_wready), 0);
      end
      i_bready = 1'b1;
      tick;
      i_bready = 1'b0;
      chk("b_done_bvalid",  32'(o_bvalid), 0);
      chk("b_done_awready", 32'(o_awready), 1);
      chk("b_done_wready",  32'(o_wready), 1);
      axi_read(12'h010, 0, rd, resp);
      chk("w_first_readback", rd, 32'h0BADF00D);
      axi_write(12'h014, 32'h1, 4'hF, 0, resp);
      chk("next_write_bresp", 32'(resp), 0);

      // commit edge coincides with AR handshake on the same register
      i_awaddr = 12'h014; i_wdata = 32'h2; i_wstrb = 4'hF;
      i_awvalid = 1'b1; i_wvalid = 1'b1;
      tick;
      i_awvalid = 1'b0; i_wvalid = 1'b0;
      chk("coll_bvalid_latency", 32'(o_bvalid), 0);
      i_araddr = 12'h014; i_arvalid = 1'b1;
      tick;
      i_arvalid = 1'b0;
      chk("coll_bvalid", 32'(o_bvalid), 1);
      chk("coll_rvalid", 32'(o_rvalid), 1);
      chk("coll_old_data", o_rdata, 32'h1);
      i_bready = 1'b1; i_rready = 1'b1;
      tick;
      i_bready = 1'b0; i_rready = 1'b0;
      chk("coll_bvalid_clr", 32'(o_bvalid), 0);
      chk("coll_rvalid_clr", 32'(o_rvalid), 0);
      chk("coll_rdata_kept", o_rdata, 32'h1);
      axi_read(12'h014, 0, rd, resp);
      chk("coll_new_data", rd, 32'h2);

      // reset while both responses are pending
      i_awaddr = 12'h018; i_wdata = 32'h77; i_wstrb = 4'hF;
      i_awvalid = 1'b1; i_wvalid = 1'b1;
      tick;
      i_awvalid = 1'b0; i_wvalid = 1'b0;
      tick;
      i_araddr = 12'h014; i_arvalid = 1'b1;
      tick;
      i_arvalid = 1'b0;
      chk("pre_rst_bvalid", 32'(o_bvalid), 1);
      chk("pre_rst_rvalid", 32'(o_rvalid), 1);
      i_rst = 1'b1;
      tick;
      chk("mid_rst_bvalid",  32'(o_bvalid), 0);
      chk("mid_rst_rvalid",  32'(o_rvalid), 0);
      chk("mid_rst_rdata",   o_rdata, 0);
      chk("mid_rst_awready", 32'(o_awready), 0);
      chk("mid_rst_arready", 32'(o_arready), 0);
      i_rst = 1'b0;
      chk("mid_rel_wready",  32'(o_wready), 0);
      chk("mid_rel_arready", 32'(o_arready), 0);
      tick;
      chk("mid_en_arready", 32'(o_arready), 1);
      chk("mid_en_wready",  32'(o_wready), 1);
      axi_read(12'h014, 0, rd, resp);
      chk("mid_rst_reg5", rd, 0);
      axi_read(12'h018, 0, rd, resp);
      chk("mid_rst_reg6", rd, 0);

      // randomized traffic against the model, starting from a clean reset
      i_rst = 1'b1;
      tick;
      i_rst = 1'b0;
      tick;
      for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
      for (int t = 0; t < 300; t++) begin
         a = AW'($urandom_range(0, (NREGS + 4) * 4 - 1));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            exp_resp = model_write(a, d, s);
            axi_write(a, d, s, int'($urandom_range(0, 2)), resp);
            chk($sformatf("rnd%0d_bresp", t), 32'(resp), 32'(exp_resp));
         end else begin
            exp_resp = model_read(a, exp_d);
            axi_read(a, int'($urandom_range(0, 2)), rd, resp);
            chk($sformatf("rnd%0d_rdata", t), rd, exp_d);
            chk($sformatf("rnd%0d_rresp", t), 32'(resp), 32'(exp_resp));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
